// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the two S3 stages.
// The build macro DMEM_ARB_ST_LD_BYPASS_EN is consumed by dmem_arbiter, not here.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    P0_ACC = 2'd1,
    P1_ACC = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  // inst_type encodings shared with the decoder and HCU
  localparam logic [2:0] INST_LDR = 3'b011;
  localparam logic [2:0] INST_STR = 3'b100;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Serializes the P0/P1 S3 memory accesses onto one data-memory port, P0 first.
// Define DMEM_ARB_ST_LD_BYPASS_EN to forward a P0 store to a same-address P1 load.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              stall_s3,
  output logic [CNT_W-1:0]  stall_cnt,
  output arb_state_e        dbg_state
);

  // Handshake: an access is presented while mem_req=1 with mem_we/addr/wdata
  // held constant, and completes in the first cycle where mem_ack=1 (which may
  // be the first cycle of mem_req); mem_ack outside an ACC state is ignored.

  arb_state_e        state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] p0_rdata_q;
  logic [DATA_W-1:0] p1_rdata_q;
  logic              bypass_q;
  logic              bypass_d;

`ifdef DMEM_ARB_ST_LD_BYPASS_EN
  assign bypass_d = p0_req & p0_we & p1_req & ~p1_we & (p0_addr == p1_addr);
`else
  assign bypass_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      bypass_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bypass_q <= bypass_d;
          if (p0_req) begin
            state_q     <= P0_ACC;
            mem_req_q   <= 1'b1;
            mem_we_q    <= p0_we;
            mem_addr_q  <= p0_addr;
            mem_wdata_q <= p0_wdata;
          end else if (p1_req) begin
            state_q     <= P1_ACC;
            mem_req_q   <= 1'b1;
            mem_we_q    <= p1_we;
            mem_addr_q  <= p1_addr;
            mem_wdata_q <= p1_wdata;
          end
        end
        P0_ACC: begin
          if (mem_ack) begin
            if (!mem_we_q) begin
              p0_rdata_q <= mem_rdata;
            end
            // A bypassed pair never issues the P1 load; the store data is its result
            if (bypass_q) begin
              p1_rdata_q <= mem_wdata_q;
            end
            if (p1_req && !bypass_q) begin
              state_q     <= P1_ACC;
              mem_we_q    <= p1_we;
              mem_addr_q  <= p1_addr;
              mem_wdata_q <= p1_wdata;
            end else begin
              state_q   <= DONE;
              mem_req_q <= 1'b0;
            end
          end
        end
        P1_ACC: begin
          if (mem_ack) begin
            if (!mem_we_q) begin
              p1_rdata_q <= mem_rdata;
            end
            state_q   <= DONE;
            mem_req_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall_s3 = 1'b0;
    case (state_q)
      IDLE:           stall_s3 = p0_req | p1_req;
      P0_ACC, P1_ACC: stall_s3 = 1'b1;
      default:        stall_s3 = 1'b0;
    endcase
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_s3),
    .count (stall_cnt)
  );

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              p0_req, p1_req, p0_we, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              stall_s3;
  logic [CNT_W-1:0]  stall_cnt;
  arb_state_e        dbg_state;

  logic              sat_inc;
  logic [2:0]        sat_count;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  int acc_base = 0;

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_req    (p0_req),
    .p1_req    (p1_req),
    .p0_we     (p0_we),
    .p1_we     (p1_we),
    .p0_addr   (p0_addr),
    .p1_addr   (p1_addr),
    .p0_wdata  (p0_wdata),
    .p1_wdata  (p1_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .p0_rdata  (p0_rdata),
    .p1_rdata  (p1_rdata),
    .stall_s3  (stall_s3),
    .stall_cnt (stall_cnt),
    .dbg_state (dbg_state)
  );

  sat_counter #(
    .CNT_W (3)
  ) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sat_inc),
    .count (sat_count)
  );

  // memory model: ack after ack_delay waiting cycles, or forced
  logic [DATA_W-1:0] mem_arr [0:(1<<ADDR_W)-1];
  int unsigned       ack_delay;
  logic              ack_force;
  int unsigned       wait_cnt;
  int                acc_cnt;

  assign mem_ack   = ack_force | (mem_req && (wait_cnt >= ack_delay));
  assign mem_rdata = mem_arr[mem_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem_arr[i] <= '0;
      mem_arr[9'h010] <= 16'hBEEF;
      mem_arr[9'h020] <= 16'hDEAD;
      mem_arr[9'h030] <= 16'h5A5A;
      mem_arr[9'h040] <= 16'h0C0D;
      wait_cnt <= 0;
      acc_cnt  <= 0;
    end else if (mem_req && mem_ack) begin
      wait_cnt <= 0;
      acc_cnt  <= acc_cnt + 1;
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    sat_inc = 1'b0;
    ack_delay = 0;
    ack_force = 1'b0;
    clear_reqs();
    #3;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_p0_rdata", 32'(p0_rdata), 32'd0);
    check("rst_p1_rdata", 32'(p1_rdata), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_stall_s3", 32'(stall_s3), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    #9 rst_n = 1'b1;
    tick();

    // bubble in both S3 stages, stray ack must be ignored
    ack_force = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bubble_stall_s3", 32'(stall_s3), 32'd0);
      check("bubble_mem_req", 32'(mem_req), 32'd0);
    end
    ack_force = 1'b0;
    check("bubble_stall_cnt", 32'(stall_cnt), 32'd0);
    check("bubble_state", 32'(dbg_state), 32'(IDLE));
    check("bubble_p0_rdata", 32'(p0_rdata), 32'd0);

    // P0 LDR 0x010, same-cycle ack
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h010;
    #1;
    check("ld0_idle_stall", 32'(stall_s3), 32'd1);
    tick();
    check("ld0_acc_state", 32'(dbg_state), 32'(P0_ACC));
    check("ld0_acc_req", 32'(mem_req), 32'd1);
    check("ld0_acc_addr", 32'(mem_addr), 32'h010);
    check("ld0_acc_we", 32'(mem_we), 32'd0);
    check("ld0_acc_cnt", 32'(stall_cnt), 32'd1);
    tick();
    check("ld0_done_state", 32'(dbg_state), 32'(DONE));
    check("ld0_done_stall", 32'(stall_s3), 32'd0);
    check("ld0_done_req", 32'(mem_req), 32'd0);
    check("ld0_p0_rdata", 32'(p0_rdata), 32'hBEEF);
    check("ld0_p1_rdata", 32'(p1_rdata), 32'd0);
    exp_cnt = 2;
    check("ld0_stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
    clear_reqs();
    tick();
    check("ld0_back_idle", 32'(dbg_state), 32'(IDLE));

    // P0 STR 0x020<-0x1234, P1 LDR 0x020
    acc_base = acc_cnt;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h020; p0_wdata = 16'h1234;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h020;
    #1;
    check("stld_idle_stall", 32'(stall_s3), 32'd1);
    tick();
    check("stld_p0_state", 32'(dbg_state), 32'(P0_ACC));
    check("stld_p0_we", 32'(mem_we), 32'd1);
    check("stld_p0_addr", 32'(mem_addr), 32'h020);
    check("stld_p0_wdata", 32'(mem_wdata), 32'h1234);
`ifdef DMEM_ARB_ST_LD_BYPASS_EN
    tick();
    check("stld_done_state", 32'(dbg_state), 32'(DONE));
    check("stld_accesses", 32'(acc_cnt - acc_base), 32'd1);
    exp_cnt = exp_cnt + 2;
`else
    tick();
    check("stld_p1_state", 32'(dbg_state), 32'(P1_ACC));
    check("stld_p1_we", 32'(mem_we), 32'd0);
    check("stld_p1_addr", 32'(mem_addr), 32'h020);
    check("stld_p1_stall", 32'(stall_s3), 32'd1);
    tick();
    check("stld_done_state", 32'(dbg_state), 32'(DONE));
    check("stld_accesses", 32'(acc_cnt - acc_base), 32'd2);
    exp_cnt = exp_cnt + 3;
`endif
    check("stld_p1_rdata", 32'(p1_rdata), 32'h1234);
    check("stld_p0_rdata_kept", 32'(p0_rdata), 32'hBEEF);
    check("stld_stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
    clear_reqs();
    tick();

    // P1 LDR 0x030 alone, ack delayed 3 cycles
    ack_delay = 3;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h030;
    #1;
    check("ld1_idle_stall", 32'(stall_s3), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ld1_acc_state", 32'(dbg_state), 32'(P1_ACC));
      check("ld1_acc_req", 32'(mem_req), 32'd1);
      check("ld1_acc_addr", 32'(mem_addr), 32'h030);
    end
    tick();
    exp_cnt = exp_cnt + 5;
    check("ld1_done_state", 32'(dbg_state), 32'(DONE));
    check("ld1_done_req", 32'(mem_req), 32'd0);
    check("ld1_p1_rdata", 32'(p1_rdata), 32'h5A5A);
    check("ld1_p0_rdata_kept", 32'(p0_rdata), 32'hBEEF);
    check("ld1_stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
    clear_reqs();
    tick();

    // reset in P0_ACC before ack, request retained across reset
    ack_delay = 10;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h040;
    tick();
    check("rst_mid_pre_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(mem_req), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    check("rst_mid_p0_rdata", 32'(p0_rdata), 32'd0);
    check("rst_mid_p1_rdata", 32'(p1_rdata), 32'd0);
    check("rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_mid_stall_s3", 32'(stall_s3), 32'd1);
    #2;
    rst_n = 1'b1;
    ack_delay = 0;
    tick();
    check("restart_state", 32'(dbg_state), 32'(P0_ACC));
    check("restart_addr", 32'(mem_addr), 32'h040);
    check("restart_cnt", 32'(stall_cnt), 32'd1);
    tick();
    check("restart_done", 32'(dbg_state), 32'(DONE));
    check("restart_p0_rdata", 32'(p0_rdata), 32'h0C0D);
    check("restart_stall_cnt", 32'(stall_cnt), 32'd2);
    clear_reqs();
    tick();

    // saturation of a narrow counter instance
    sat_inc = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("sat_count", 32'(sat_count), (i > 7) ? 32'd7 : 32'(i));
    end
    sat_inc = 1'b0;
    tick();
    check("sat_hold", 32'(sat_count), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory port between the two S3 (MEMWRT) stages of the dual-issue pipeline. When P0 and P1 both hold an LDR/STR in S3, accesses are serialized in program order (P0 first) while the S3 advance is stalled. Load data is returned per pipe. The block sits between the S3 pipeline registers and the data-memory handshake, beside HCU, whose stalls it complements.

## Interface
Parameters:
- DATA_W, 16, data word width
- ADDR_W, 9, memory address width
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low; one clock domain
- p0_req, p1_req  in  1  S3 instruction is LDR/STR; held stable while stall_s3=1
- p0_we, p1_we  in  1  1=STR, 0=LDR
- p0_addr, p1_addr  in  ADDR_W  access address
- p0_wdata, p1_wdata  in  DATA_W  store data
- mem_req  out  1  memory access request
- mem_we  out  1  write enable of current access
- mem_addr  out  ADDR_W  address of current access
- mem_wdata  out  DATA_W  write data of current access
- mem_ack  in  1  access complete; may assert in the same cycle as mem_req
- mem_rdata  in  DATA_W  read data, valid with mem_ack on a read
- p0_rdata, p1_rdata  out  DATA_W  registered load results
- stall_s3  out  1  hold S0–S3 of both pipes
- stall_cnt  out  CNT_W  saturating count of cycles with stall_s3=1

## Operation
FSM states: IDLE, P0_ACC, P1_ACC, DONE.
- IDLE
  - Go to P0_ACC if p0_req=1.
  - Otherwise go to P1_ACC if p1_req=1.
  - Otherwise stay in IDLE.
- P0_ACC: mem_req=1; mem_we, mem_addr and mem_wdata are taken from P0.
  - On mem_ack: if P0 is a load, capture mem_rdata into p0_rdata.
  - Then go to P1_ACC if p1_req=1 and P1 is not bypassed; otherwise go to DONE.
- P1_ACC: mem_req=1 with P1 fields. On mem_ack, capture p1_rdata on a load, then go to DONE.
- DONE: stall_s3=0, so the pipeline advances on this edge. Go to IDLE.

Outputs per state:
- stall_s3 = (IDLE & (p0_req|p1_req)) | P0_ACC | P1_ACC. It is combinational from state and inputs.
- mem_req=0 in IDLE and DONE.

Data rules:
- STR accesses never modify p0_rdata or p1_rdata.
- Each rdata register holds its value until its next load capture.
- Program order is P0 before P1. As a result, STR→LDR and STR→STR to the same address in one S3 pair resolve correctly.

stall_cnt:
- Increments on each cycle with stall_s3=1.
- Saturates at all-ones.

Reset:
- State=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, p0_rdata=0, p1_rdata=0, stall_cnt=0. stall_s3 then follows its equation.
- Reset asserted mid-access drops mem_req immediately. The memory abandons any unacknowledged request.

## Timing
- No request in S3: zero stall cycles; IDLE persists.
- Single access with mem_ack in the same cycle: 2 stall cycles (IDLE, P0_ACC or P1_ACC), then DONE.
- Dual access with mem_ack in the same cycle: 3 stall cycles, then DONE.
- Each cycle of mem_ack delay adds one stall cycle.
- pN_rdata is valid from the cycle after capture, which is at the latest the DONE cycle. The S4 register samples it on the DONE edge.
- mem_* outputs are stable for the whole ACC state.
- mem_ack is ignored outside P0_ACC and P1_ACC.

## Configuration
- DMEM_ARB_ST_LD_BYPASS_EN defined:
  - Bypass condition, checked in IDLE: p0_req & p0_we & p1_req & !p1_we & (p0_addr==p1_addr).
  - When it holds, P0_ACC also loads p0_wdata into p1_rdata on mem_ack and goes straight to DONE.
  - The pair costs 2 stall cycles.
  - A bypass flag is registered on leaving IDLE.
- Undefined: no bypass; P1_ACC is always performed when p1_req=1.

## Structure
- Shared package dmem_arb_pkg: state enum (IDLE, P0_ACC, P1_ACC, DONE); the LDR=3'b011 and STR=3'b100 inst_type constants shared with the decoder and HCU.
- One sub-module, sat_counter (parameter CNT_W, inc input, count output), for stall_cnt.
- All other logic in a single module.

## Test plan
- Bubble in both S3 stages (p0_req=p1_req=0) for 10 cycles -> stall_s3=0, mem_req=0, stall_cnt=0.
- P0 LDR addr 0x010 alone, mem_ack same cycle, mem_rdata=0xBEEF -> stall_s3=1 for 2 cycles; p0_rdata=0xBEEF in DONE; stall_cnt=2.
- P0 STR 0x020←0x1234 and P1 LDR 0x020, macro undefined -> two accesses in order (write, then read returning 0x1234); p1_rdata=0x1234; 3 stall cycles.
- Same stimulus with DMEM_ARB_ST_LD_BYPASS_EN defined -> one write access only; p1_rdata=0x1234; 2 stall cycles.
- P1 LDR only, with mem_ack delayed 3 cycles -> mem_req held 4 cycles with P1 address; p0_rdata unchanged; 5 stall cycles.
- rst_n pulled low in P0_ACC before mem_ack -> mem_req=0 immediately; after release, state IDLE, rdata=0, stall_cnt=0. A retained request restarts at P0_ACC.
